// File: rtl/cred_tx_scheduler.sv
// Purpose: round-robin frame scheduler that whitens credential bytes with an 8-bit LFSR keystream before transmission.
// Latency: 1 cycle arbitration, 1 cycle output register; 1 byte/cycle while tx_ready is held high.
// Backpressure: granted req_ready = !tx_valid | tx_ready; tx_* hold while tx_valid & !tx_ready.
module cred_tx_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int KEY_LIFE = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           key_seed,
    input  logic                 key_valid,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 key_loaded,
    output logic                 err_nokey
);

    typedef enum logic [1:0] {NOKEY, IDLE, XFER, DRAIN} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_lfsr, r_frame_cnt, r_tx_data;
    logic          r_tx_valid, r_tx_last, r_err_nokey;
    logic [GW-1:0] r_grant, r_last_grant, w_winner, w_cand;
    logic          w_key_ok, w_slot_free, w_tx_fire, w_accept, w_any_req, w_found, w_key_expire;
    logic [7:0]    w_gnt_dat, w_lfsr_step, w_cnt_inc;

    // A zero seed would lock the LFSR at zero, i.e. cleartext, so it is refused.
    assign w_key_ok     = key_valid && (key_seed != 8'h00);
    assign w_any_req    = |req_valid;
    assign w_tx_fire    = r_tx_valid && tx_ready;
    assign w_slot_free  = !r_tx_valid || tx_ready;
    assign w_gnt_dat    = req_data[{r_grant, 3'b000} +: 8];
    assign w_accept     = (r_state == XFER) && req_valid[r_grant] && w_slot_free;
    assign w_lfsr_step  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_cnt_inc    = r_frame_cnt + 8'd1;
    assign w_key_expire = (w_cnt_inc == 8'(KEY_LIFE));

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign tx_last    = r_tx_last;
    assign grant_id   = r_grant;
    assign busy       = (r_state == XFER) || (r_state == DRAIN);
    assign key_loaded = (r_state != NOKEY);
    assign err_nokey  = r_err_nokey;

    // Round-robin pick: first valid requester strictly after the last grant, wrapping.
    always_comb begin
        w_winner = r_last_grant;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = GW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= NOKEY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and the per-requester ready strobes.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            NOKEY: begin
                if (w_key_ok) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (w_any_req) w_state_nxt = XFER;
            end
            XFER: begin
                req_ready[r_grant] = w_slot_free;
                if (w_accept && req_last[r_grant]) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_tx_fire) w_state_nxt = w_key_expire ? NOKEY : IDLE;
            end
            default: w_state_nxt = NOKEY;
        endcase
    end

    // Datapath: key/LFSR, grant registers, output byte register and frame counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr       <= 8'h00;
            r_frame_cnt  <= 8'h00;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_tx_last    <= 1'b0;
            r_err_nokey  <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
        end else begin
            r_err_nokey <= (w_state_nxt == NOKEY) && w_any_req;
            case (r_state)
                NOKEY, IDLE: begin
                    if (w_key_ok) begin
                        r_lfsr      <= key_seed;
                        r_frame_cnt <= 8'h00;
                    end
                    if ((r_state == IDLE) && w_any_req) begin
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        r_tx_data  <= w_gnt_dat ^ r_lfsr;
                        r_tx_last  <= req_last[r_grant];
                        r_tx_valid <= 1'b1;
                        r_lfsr     <= w_lfsr_step;
                    end else if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_tx_fire) begin
                        r_tx_valid  <= 1'b0;
                        r_tx_last   <= 1'b0;
                        r_frame_cnt <= w_cnt_inc;
                        // Retire the key so nothing further can be whitened with it.
                        if (w_key_expire) r_lfsr <= 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cred_tx_scheduler.sv
// Bench for cred_tx_scheduler: directed scenarios plus randomized frames vs a frame-level model.
// Two instances share stimulus: dut (KEY_LIFE=16) and dut_b (KEY_LIFE=2, used for expiry).
// Inputs driven at negedge, outputs sampled 1 time unit later.
module tb_cred_tx_scheduler;
    localparam int N = 4;

    logic           clk, reset, key_valid, tx_ready;
    logic [7:0]     key_seed;
    logic [N-1:0]   req_valid, req_last, req_ready, req_ready_b;
    logic [8*N-1:0] req_data;
    logic [7:0]     tx_data, tx_data_b;
    logic           tx_valid, tx_last, busy, key_loaded, err_nokey;
    logic           tx_valid_b, tx_last_b, busy_b, key_loaded_b, err_nokey_b;
    logic [1:0]     grant_id, grant_id_b;

    int n_tests = 0;
    int n_fail  = 0;

    cred_tx_scheduler #(.NUM_REQ(N), .KEY_LIFE(16)) dut (
        .clk(clk), .reset(reset), .key_seed(key_seed), .key_valid(key_valid),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .key_loaded(key_loaded), .err_nokey(err_nokey)
    );

    cred_tx_scheduler #(.NUM_REQ(N), .KEY_LIFE(2)) dut_b (
        .clk(clk), .reset(reset), .key_seed(key_seed), .key_valid(key_valid),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_last(tx_last_b), .tx_ready(tx_ready),
        .grant_id(grant_id_b), .busy(busy_b), .key_loaded(key_loaded_b), .err_nokey(err_nokey_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keystream sequence as defined by the feedback polynomial.
    function automatic logic [7:0] ks_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic do_reset_and_key(input logic [7:0] seed);
        @(negedge clk);
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; key_valid = 1'b0; tx_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0; key_valid = 1'b1; key_seed = seed;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_tests++; if ({tx_valid, tx_last, busy, key_loaded, err_nokey} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {tx_valid, tx_last, busy, key_loaded, err_nokey}); end
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    endtask

    task automatic test_key_gating;
        @(negedge clk);
        reset = 1'b0; req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h3C; tx_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_tests++; if (err_nokey !== 1'b1) begin n_fail++; $display("FAIL nokey_err: cycle %0d got %b want 1", c, err_nokey); end
            n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL nokey_ready: cycle %0d got %b want 0000", c, req_ready); end
            n_tests++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL nokey_tx_valid: cycle %0d got %b want 0", c, tx_valid); end
        end
        req_valid = '0; key_valid = 1'b1; key_seed = 8'h00;
        @(negedge clk); #1;
        n_tests++; if (key_loaded !== 1'b0) begin n_fail++; $display("FAIL zero_seed: key_loaded got %b want 0", key_loaded); end
        key_seed = 8'h01;
        @(negedge clk); #1;
        n_tests++; if (key_loaded !== 1'b1) begin n_fail++; $display("FAIL seed_load: key_loaded got %b want 1", key_loaded); end
        n_tests++; if (err_nokey !== 1'b0) begin n_fail++; $display("FAIL seed_load_err: got %b want 0", err_nokey); end
        key_valid = 1'b0;
    endtask

    task automatic test_whitening;
        req_valid = 4'b0001; req_data[7:0] = 8'hA5; req_last = '0; tx_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++; if ({busy, grant_id, req_ready, tx_valid} !== {1'b1, 2'd0, 4'b0001, 1'b0}) begin n_fail++; $display("FAIL wh_grant: got busy=%b gid=%0d rdy=%b txv=%b want 1 0 0001 0", busy, grant_id, req_ready, tx_valid); end
        @(negedge clk); #1;
        n_tests++; if ({tx_valid, tx_data, tx_last} !== {1'b1, 8'hA4, 1'b0}) begin n_fail++; $display("FAIL wh_byte0: got v=%b d=%h l=%b want 1 a4 0", tx_valid, tx_data, tx_last); end
        req_data[7:0] = 8'h5A; req_last = 4'b0001;
        @(negedge clk); #1;
        n_tests++; if ({tx_valid, tx_data, tx_last} !== {1'b1, 8'h58, 1'b1}) begin n_fail++; $display("FAIL wh_byte1: got v=%b d=%h l=%b want 1 58 1", tx_valid, tx_data, tx_last); end
        n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL wh_drain_ready: got %b want 0000", req_ready); end
        req_valid = '0; req_last = '0;
        @(negedge clk); #1;
        n_tests++; if ({tx_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL wh_done: got txv=%b busy=%b want 0 0", tx_valid, busy); end
    endtask

    task automatic test_round_robin;
        logic [7:0] d [4];
        logic [7:0] l;
        int rdy_cnt [4];
        int nhs, nout, cyc;
        do_reset_and_key(8'h5C);
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        l = 8'h5C; nhs = 0; nout = 0; cyc = 0;
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        req_data = {d[3], d[2], d[1], d[0]}; req_valid = 4'hF; req_last = 4'hF; tx_ready = 1'b1;
        while (cyc < 60 && nout < 5) begin
            @(negedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) rdy_cnt[i]++;
                if (req_valid[i] && req_ready[i]) begin
                    n_tests++; if (i != nhs % 4) begin n_fail++; $display("FAIL rr_order: handshake %0d got req %0d want %0d", nhs, i, nhs % 4); end
                    nhs++;
                end
            end
            if (tx_valid && tx_ready) begin
                n_tests++; if (tx_data !== (d[nout % 4] ^ l)) begin n_fail++; $display("FAIL rr_data: frame %0d got %h want %h", nout, tx_data, d[nout % 4] ^ l); end
                l = ks_next(l);
                nout++;
            end
            cyc++;
        end
        req_valid = '0;
        n_tests++; if (nout != 5) begin n_fail++; $display("FAIL rr_count: got %0d frames want 5", nout); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rdy_cnt[i] != ((i == 0) ? 2 : 1)) begin n_fail++; $display("FAIL rr_ready_cycles: req %0d got %0d want %0d", i, rdy_cnt[i], (i == 0) ? 2 : 1); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] dat [6];
        logic [7:0] expd [6];
        logic [7:0] l;
        int ptr, nout, stall, cyc;
        do_reset_and_key(8'h3B);
        l = 8'h3B;
        for (int k = 0; k < 6; k++) begin
            dat[k] = 8'($urandom_range(0, 255));
            expd[k] = dat[k] ^ l;
            l = ks_next(l);
        end
        ptr = 0; nout = 0; stall = 4; cyc = 0;
        while (cyc < 80 && nout < 6) begin
            @(negedge clk);
            req_valid = (ptr < 6) ? 4'b0010 : 4'b0000;
            req_data[15:8] = (ptr < 6) ? dat[ptr] : 8'h00;
            req_last = (ptr == 5) ? 4'b0010 : 4'b0000;
            tx_ready = !(nout == 2 && stall > 0);
            #1;
            if (tx_valid && !tx_ready) begin
                n_tests++; if (tx_data !== expd[nout]) begin n_fail++; $display("FAIL bp_hold: got %h want %h", tx_data, expd[nout]); end
                n_tests++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL bp_ready: got %b want 0000", req_ready); end
                stall--;
            end
            if (tx_valid && tx_ready) begin
                n_tests++; if ({tx_data, tx_last} !== {expd[nout], nout == 5}) begin n_fail++; $display("FAIL bp_data: byte %0d got %h/%b want %h/%b", nout, tx_data, tx_last, expd[nout], nout == 5); end
                nout++;
            end
            if (req_valid[1] && req_ready[1]) ptr++;
            cyc++;
        end
        req_valid = '0; req_last = '0; tx_ready = 1'b1;
        n_tests++; if (nout != 6 || ptr != 6) begin n_fail++; $display("FAIL bp_count: got out=%0d in=%0d want 6 6", nout, ptr); end
        n_tests++; if (stall != 0) begin n_fail++; $display("FAIL bp_stall_seen: got %0d stall cycles left want 0", stall); end
    endtask

    task automatic test_key_expiry;
        logic [7:0] l;
        int nf;
        do_reset_and_key(8'h21);
        l = 8'h21; nf = 0;
        req_valid = 4'b0100; req_data[23:16] = 8'h77; req_last = 4'b0100; tx_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (tx_valid_b && tx_ready) begin
                n_tests++; if (tx_data_b !== (8'h77 ^ l)) begin n_fail++; $display("FAIL exp_data: frame %0d got %h want %h", nf, tx_data_b, 8'h77 ^ l); end
                l = ks_next(l);
                nf++;
            end
        end
        n_tests++; if (nf != 2) begin n_fail++; $display("FAIL exp_frames: got %0d want 2", nf); end
        n_tests++; if ({key_loaded_b, err_nokey_b, busy_b, tx_valid_b} !== 4'b0100) begin n_fail++; $display("FAIL exp_state: got kl=%b err=%b busy=%b txv=%b want 0 1 0 0", key_loaded_b, err_nokey_b, busy_b, tx_valid_b); end
        n_tests++; if (req_ready_b !== 4'h0) begin n_fail++; $display("FAIL exp_ready: got %b want 0000", req_ready_b); end
        req_valid = '0; req_last = '0;
    endtask

    task automatic test_reset_midframe;
        do_reset_and_key(8'h9E);
        req_valid = 4'b1000; req_data[31:24] = 8'h10; req_last = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if ({busy, tx_valid} !== 2'b11) begin n_fail++; $display("FAIL mid_inflight: got busy=%b txv=%b want 1 1", busy, tx_valid); end
        reset = 1'b1;
        #1;
        n_tests++; if ({tx_data, tx_valid, tx_last, busy, key_loaded, err_nokey, grant_id, req_ready} !== 19'b0) begin n_fail++; $display("FAIL mid_reset_outputs: got d=%h v=%b l=%b b=%b kl=%b e=%b g=%0d r=%b want all 0", tx_data, tx_valid, tx_last, busy, key_loaded, err_nokey, grant_id, req_ready); end
        @(negedge clk);
        reset = 1'b0; req_valid = 4'b1001; tx_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++; if ({req_ready, key_loaded, err_nokey} !== 6'b000001) begin n_fail++; $display("FAIL mid_needs_key: got rdy=%b kl=%b err=%b want 0000 0 1", req_ready, key_loaded, err_nokey); end
        key_valid = 1'b1; key_seed = 8'h9E;
        @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk); #1;
        n_tests++; if ({busy, grant_id, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin n_fail++; $display("FAIL mid_priority: got busy=%b gid=%0d rdy=%b want 1 0 0001", busy, grant_id, req_ready); end
        req_valid = '0;
    endtask

    task automatic test_random;
        logic [7:0] rdat [4][12];
        bit         rlast [4][12];
        int         rlen [4], ptr [4], mcur [4];
        logic [7:0] exp_d [$];
        bit         exp_l [$];
        logic [7:0] seed, l;
        int nfr, flen, last, c, nout, cyc;
        bit found, more, at_start;
        for (int it = 0; it < 3; it++) begin
            seed = 8'($urandom_range(1, 255));
            for (int i = 0; i < 4; i++) begin
                rlen[i] = 0; ptr[i] = 0; mcur[i] = 0;
                nfr = int'($urandom_range(1, 3));
                for (int f = 0; f < nfr; f++) begin
                    flen = int'($urandom_range(1, 4));
                    for (int b = 0; b < flen; b++) begin
                        rdat[i][rlen[i]] = 8'($urandom_range(0, 255));
                        rlast[i][rlen[i]] = (b == flen - 1);
                        rlen[i]++;
                    end
                end
            end
            // Frame-level model: rotate through requesters with frames left, whiten each byte.
            exp_d.delete(); exp_l.delete();
            l = seed; last = 3; more = 1'b1;
            while (more) begin
                found = 1'b0; c = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && mcur[(last + k) % 4] < rlen[(last + k) % 4]) begin
                        found = 1'b1; c = (last + k) % 4;
                    end
                end
                if (!found) more = 1'b0;
                else begin
                    do begin
                        exp_d.push_back(rdat[c][mcur[c]] ^ l);
                        exp_l.push_back(rlast[c][mcur[c]]);
                        l = ks_next(l);
                        mcur[c]++;
                    end while (!rlast[c][mcur[c] - 1]);
                    last = c;
                end
            end
            do_reset_and_key(seed);
            nout = 0; cyc = 0;
            while (cyc < 2000 && nout < exp_d.size()) begin
                @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    at_start = (ptr[i] == 0) || rlast[i][ptr[i] - 1];
                    req_valid[i] = (ptr[i] < rlen[i]) && (at_start || $urandom_range(0, 3) != 0);
                    req_data[8*i +: 8] = (ptr[i] < rlen[i]) ? rdat[i][ptr[i]] : 8'h00;
                    req_last[i] = (ptr[i] < rlen[i]) ? rlast[i][ptr[i]] : 1'b0;
                end
                tx_ready = ($urandom_range(0, 3) != 0);
                #1;
                n_tests++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL rand_onehot: req_ready %b", req_ready); end
                if (tx_valid && tx_ready) begin
                    n_tests++; if ({tx_data, tx_last} !== {exp_d[nout], exp_l[nout]}) begin n_fail++; $display("FAIL rand_data: iter %0d byte %0d got %h/%b want %h/%b", it, nout, tx_data, tx_last, exp_d[nout], exp_l[nout]); end
                    nout++;
                end
                for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) ptr[i]++;
                cyc++;
            end
            n_tests++; if (nout != exp_d.size()) begin n_fail++; $display("FAIL rand_count: iter %0d got %0d bytes want %0d", it, nout, exp_d.size()); end
            req_valid = '0;
        end
    endtask

    initial begin
        reset = 1'b1; key_valid = 1'b0; key_seed = 8'h00;
        req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        test_reset();
        test_key_gating();
        test_whitening();
        test_round_robin();
        test_backpressure();
        test_key_expiry();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cred_tx_scheduler.md
# cred_tx_scheduler

Arbitrating scheduler that shares one byte-wide credential transmit channel among NUM_REQ requesters. It refuses all traffic until a keystream seed is loaded, then whitens every byte with an 8-bit LFSR keystream, so credentials never leave the block in cleartext. It grants whole frames round-robin, streams them over a valid/ready channel, and retires the key after KEY_LIFE frames. It sits between credential sources (password entry, token stores) and the link transmitter.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- KEY_LIFE, 16: frames sent per key before the key expires, 1..255.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_seed  in  8  keystream seed.
- key_valid  in  1  load key_seed this cycle.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  requester i byte at [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of the frame.
- req_ready  out  NUM_REQ  byte accepted when valid&ready.
- tx_data  out  8  whitened byte.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final byte of the frame.
- tx_ready  in  1  downstream accept.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  high in XFER and DRAIN.
- key_loaded  out  1  high when state is not NOKEY.
- err_nokey  out  1  high while in NOKEY and any req_valid is set.

## Operation
- States: NOKEY, IDLE, XFER, DRAIN. Reset enters NOKEY.
- NOKEY:
  - key_valid with key_seed != 0 loads lfsr <= key_seed, clears frame_cnt, and moves to IDLE.
  - A zero seed is ignored.
  - All req_ready are 0.
- IDLE:
  - key_valid with a nonzero seed reseeds and clears frame_cnt.
  - If any req_valid is set, pick a winner round-robin, searching from last_grant+1 upward with wrap. Register grant_id and last_grant, then go to XFER.
  - After reset, last_grant = NUM_REQ-1, so requester 0 has top priority.
- XFER:
  - req_ready[grant_id] = !tx_valid | tx_ready. All other req_ready are 0.
  - On accept: tx_data <= req_data[g] ^ lfsr, tx_last <= req_last[g], tx_valid <= 1, and the lfsr advances.
  - If tx_valid & tx_ready and nothing is accepted, tx_valid <= 0.
  - Accepting a byte with req_last set moves to DRAIN.
  - key_valid is ignored.
- DRAIN:
  - Holds tx_* until tx_valid & tx_ready, then clears tx_valid and tx_last and increments frame_cnt.
  - If frame_cnt reaches KEY_LIFE, go to NOKEY and clear lfsr to 0. Otherwise go to IDLE.
  - key_valid is ignored.
- LFSR step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- The LFSR advances only on accepted bytes. A nonzero seed never reaches 0.
- tx_data, tx_last and tx_valid are stable while tx_valid & !tx_ready.
- A requester that drops req_valid mid-frame stalls the channel. There is no timeout.
- Reset at any time: all outputs 0, state NOKEY, lfsr 0, frame_cnt 0, last_grant NUM_REQ-1. An in-flight frame is discarded.

## Timing
- Reset values: tx_data 0, tx_valid 0, tx_last 0, req_ready 0, grant_id 0, busy 0, key_loaded 0, err_nokey 0.
- key_loaded rises the cycle after the key_valid edge.
- Arbitration takes 1 cycle: req_valid seen in IDLE at edge N gives grant at N. req_ready is asserted during the following cycle, so the first byte is accepted at edge N+1 and tx_valid is high after N+1.
- Output register latency is 1 cycle. Throughput is 1 byte per cycle while tx_ready is held high.
- Frame turnaround: DRAIN exits at the edge where the last byte is taken. The next grant happens at the following edge, so there are 2 idle tx cycles between frames when tx_ready is held high.
- req_ready is combinational from tx_valid, tx_ready and the state. There are no other combinational paths from inputs to outputs.

## Test plan
- Key gating: no key, req_valid[0]=1 for 5 cycles -> err_nokey=1, req_ready=0, tx_valid=0 throughout. Seed 0x00 -> stays NOKEY. Seed 0x01 -> key_loaded=1 next cycle.
- Whitening: seed 0x01, requester 0 sends 0xA5, 0x5A(last) with tx_ready=1 -> tx 0xA4, then 0x58 with tx_last=1 on the second byte. LFSR values are 0x01, 0x02.
- Round robin: all four requesters valid, one-byte frames -> grant order 0,1,2,3,0. Each req_ready fires exactly once per frame.
- Backpressure: tx_ready=0 for 4 cycles mid-frame -> tx_data is held, req_ready=0, the LFSR does not advance, and no bytes are lost or duplicated.
- Key expiry: KEY_LIFE=2, send three frames -> the third frame blocks. The state returns to NOKEY after frame 2 drains, with key_loaded=0 and err_nokey=1.
- Reset mid-frame: assert reset during XFER -> all outputs 0 immediately. After release, a new key is required and requester 0 has top priority.
